// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
    localparam logic [2:0] HALT_OP    = 3'b111;
    localparam logic [1:0] HALT_FUNCT = 2'b11;
    localparam int PCW_DEF  = 10;
    localparam int IW_DEF   = 9;
    localparam int CNTW_DEF = 16;
endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: pair of clearable, enabled, wrapping performance counters
// Ports: clk, reset_n (async low), clr (sync clear, wins over enables),
//        cyc_en/instr_en (increment enables), cyc_count/instr_count (values)
module fetch_perf_ctr #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            cyc_en,
    input  logic            instr_en,
    output logic [CNTW-1:0] cyc_count,
    output logic [CNTW-1:0] instr_count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_count   <= '0;
            instr_count <= '0;
        end else if (clr) begin
            cyc_count   <= '0;
            instr_count <= '0;
        end else begin
            if (cyc_en)   cyc_count   <= cyc_count + 1'b1;
            if (instr_en) instr_count <= instr_count + 1'b1;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, synchronous ROM addressing, branch redirect and HALT detection
// Ports: clk, reset_n (async low); start/start_addr launch execution; stall holds
//        the presented word; branch_taken/branch_target redirect; imem_addr/imem_rdata
//        drive the ROM; instr/instr_valid/pc_out feed the decoder; busy/done status;
//        cyc_count/instr_count are live only when INSTR_FETCH_PERF_EN is defined.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PCW  = PCW_DEF,
    parameter int IW   = IW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [PCW-1:0]  start_addr,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PCW-1:0]  branch_target,
    output logic [PCW-1:0]  imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    output logic [IW-1:0]   instr,
    output logic            instr_valid,
    output logic [PCW-1:0]  pc_out,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] cyc_count,
    output logic [CNTW-1:0] instr_count
);
    fetch_state_t   state;
    logic [PCW-1:0] fetch_pc, issue_pc;
    logic           run, go, halt_word;
    assign run         = state == RUN;
    assign go          = !run && start;
    assign halt_word   = imem_rdata[IW-1 -: 3] == HALT_OP && imem_rdata[IW-4 -: 2] == HALT_FUNCT;
    assign instr_valid = run && !halt_word;
    assign instr       = instr_valid ? imem_rdata : '0;
    assign pc_out      = issue_pc;
    assign busy        = run;
    // The ROM is one cycle behind the address, so redirects go straight onto
    // imem_addr to present the target with no bubble.
    assign imem_addr = go                                 ? start_addr    :
                       run && stall                       ? issue_pc      :
                       run && instr_valid && branch_taken ? branch_target :
                       run                                ? fetch_pc      : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
            issue_pc <= '0;
            done     <= 1'b0;
        end else if (go) begin
            state    <= RUN;
            issue_pc <= start_addr;
            fetch_pc <= start_addr + 1'b1;
            done     <= 1'b0;
        end else if (run && !stall) begin
            if (halt_word) begin
                state <= HALTED;
                done  <= 1'b1;
            end else if (branch_taken) begin
                issue_pc <= branch_target;
                fetch_pc <= branch_target + 1'b1;
            end else begin
                issue_pc <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end
`ifdef INSTR_FETCH_PERF_EN
    fetch_perf_ctr #(.CNTW(CNTW)) u_perf (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (go),
        .cyc_en     (run),
        .instr_en   (instr_valid && !stall),
        .cyc_count  (cyc_count),
        .instr_count(instr_count)
    );
`else
    assign cyc_count   = '0;
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a behavioural ROM
module tb_instr_fetch;
    localparam int PCW = 10, IW = 9, CNTW = 16;
`ifdef INSTR_FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic            clk = 1'b0, reset_n = 1'b0, start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
    logic [PCW-1:0]  start_addr = '0, branch_target = '0, imem_addr, pc_out;
    logic [IW-1:0]   imem_rdata = '0, instr;
    logic            instr_valid, busy, done;
    logic [CNTW-1:0] cyc_count, instr_count;
    logic [IW-1:0]   rom [0:(1<<PCW)-1];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= rom[imem_addr];
    instr_fetch #(.PCW(PCW), .IW(IW), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .pc_out(pc_out), .busy(busy), .done(done),
        .cyc_count(cyc_count), .instr_count(instr_count)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_start(input logic [PCW-1:0] a);
        start = 1'b1;
        start_addr = a;
        step();
        start = 1'b0;
    endtask
    task automatic branch(input logic [PCW-1:0] t);
        branch_taken = 1'b1;
        branch_target = t;
        step();
        branch_taken = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < (1 << PCW); i++) rom[i] = {1'b0, 8'(i)};
        rom[10'h030] = 9'b111_11_0000;
        rom[10'h040] = 9'b111_11_1010;
        step(2);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_cyc", cyc_count, 0);
        chk("rst_icnt", instr_count, 0);
        reset_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        pulse_start(10'h010);
        chk("start_pc", pc_out, 10'h010);
        chk("start_valid", instr_valid, 1);
        chk("start_instr", instr, 9'h010);
        chk("start_busy", busy, 1);
        step();
        chk("seq1_pc", pc_out, 10'h011);
        chk("seq1_instr", instr, 9'h011);
        step();
        chk("seq2_pc", pc_out, 10'h012);
        branch(10'h005);
        chk("br_pc", pc_out, 10'h005);
        chk("br_valid", instr_valid, 1);
        chk("br_instr", instr, 9'h005);
        step();
        chk("br_next_pc", pc_out, 10'h006);
        chk("br_next_valid", instr_valid, 1);
        branch(10'h020);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 10'h100;
        #1 chk("stall_addr", imem_addr, 10'h020);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_out, 10'h020);
            chk("stall_instr", instr, 9'h020);
            chk("stall_valid", instr_valid, 1);
        end
        stall = 1'b0;
        branch_taken = 1'b0;
        step();
        chk("unstall_pc", pc_out, 10'h021);
        branch(10'h030);
        chk("halt_pc", pc_out, 10'h030);
        chk("halt_valid", instr_valid, 0);
        chk("halt_instr", instr, 0);
        chk("halt_done0", done, 0);
        step();
        chk("halted_done", done, 1);
        chk("halted_busy", busy, 0);
        chk("halted_valid", instr_valid, 0);
        step(2);
        chk("halted_hold", done, 1);
        pulse_start(10'h000);
        chk("restart_done", done, 0);
        chk("restart_pc", pc_out, 10'h000);
        chk("restart_valid", instr_valid, 1);
        start = 1'b1;
        start_addr = 10'h3FF;
        step();
        start = 1'b0;
        chk("start_ignored", pc_out, 10'h001);
        branch(10'h030);
        step();
        pulse_start(10'h3FF);
        chk("wrap_pc0", pc_out, 10'h3FF);
        chk("wrap_instr0", instr, 9'h0FF);
        step();
        chk("wrap_pc1", pc_out, 10'h000);
        chk("wrap_instr1", instr, 9'h000);
        step();
        reset_n = 1'b0;
        #1;
        chk("arst_valid", instr_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pc", pc_out, 0);
        chk("arst_addr", imem_addr, 0);
        step();
        reset_n = 1'b1;
        step();
        pulse_start(10'h03C);
        chk("perf_clr_cyc", cyc_count, 0);
        chk("perf_clr_icnt", instr_count, 0);
        step();
        stall = 1'b1;
        step(2);
        stall = 1'b0;
        chk("perf_stall_pc", pc_out, 10'h03D);
        step(3);
        chk("perf_halt_pc", pc_out, 10'h040);
        chk("perf_halt_valid", instr_valid, 0);
        step();
        chk("perf_done", done, 1);
        chk("perf_cyc", cyc_count, PERF ? 7 : 0);
        chk("perf_icnt", instr_count, PERF ? 4 : 0);
        step(3);
        chk("perf_cyc_frozen", cyc_count, PERF ? 7 : 0);
        chk("perf_icnt_frozen", instr_count, PERF ? 4 : 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream stage of the 9-bit-instruction core. Holds the program counter, drives the synchronous instruction ROM, and presents one instruction per cycle to the control decoder.
- Consumes the decoder's branch decision and target, and detects the HALT word.
- Start/done handshake with the testbench or top level.

Parameters:
- PCW, 10, program counter / instruction ROM address width.
- IW, 9, instruction width.
- CNTW, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins execution at start_addr.
- start_addr  in  PCW  first instruction address.
- stall  in  1  downstream hold; freezes the presented instruction.
- branch_taken  in  1  decoder Branch output, evaluated on the current instr.
- branch_target  in  PCW  absolute target address for a taken branch.
- imem_addr  out  PCW  ROM address (combinational); ROM returns data one cycle later.
- imem_rdata  in  IW  ROM read data.
- instr  out  IW  instruction to the decoder; 0 when instr_valid=0.
- instr_valid  out  1  instr is a live, executable instruction this cycle.
- pc_out  out  PCW  address of the presented instr.
- busy  out  1  state==RUN.
- done  out  1  HALT reached; held until the next start.
- cyc_count  out  CNTW  RUN cycles (optional feature).
- instr_count  out  CNTW  instructions retired (optional feature).

Behaviour:
- Registers:
  - fetch_pc: next sequential address.
  - issue_pc: address of the instruction now on imem_rdata; drives pc_out.
  - state: IDLE / RUN / HALTED.
  - done.
- Reset (async, reset_n=0):
  - state=IDLE, fetch_pc=0, issue_pc=0, done=0.
  - Outputs: instr=0, instr_valid=0, busy=0, imem_addr=0, counters=0.
- HALT word: imem_rdata[8:6]==3'b111 and imem_rdata[5:4]==2'b11 (unused opcode-111 funct). Low 4 bits are ignored.
- imem_addr select, in priority order:
  1. IDLE or HALTED with start: start_addr.
  2. RUN with stall: issue_pc (re-read the current word).
  3. RUN with instr_valid and branch_taken: branch_target.
  4. RUN otherwise: fetch_pc.
  5. Otherwise: 0.
- IDLE:
  - start → RUN; issue_pc<=start_addr; fetch_pc<=start_addr+1; done<=0.
  - Instruction is valid in the first RUN cycle (1-cycle start latency).
- RUN:
  - instr_valid = !halt_word. instr = imem_rdata when valid.
  - Stall: issue_pc and fetch_pc hold; instr_valid stays asserted; branch_taken is ignored (the decoder re-evaluates after release).
  - Taken branch, no stall: issue_pc<=branch_target; fetch_pc<=branch_target+1. Zero bubbles: the target instruction is presented the next cycle.
  - Sequential, no stall: issue_pc<=fetch_pc; fetch_pc<=fetch_pc+1.
  - HALT word, no stall: state→HALTED; done<=1. The HALT word is never presented valid.
  - HALT word with stall: instr_valid=0, state holds until stall drops.
  - start during RUN: ignored.
- HALTED:
  - done=1, instr_valid=0.
  - start restarts exactly as from IDLE; done clears on the same edge.
- Arithmetic: PC increments wrap modulo 2^PCW (address 2^PCW-1 is followed by 0). The branch target is taken verbatim.
- Reset mid-RUN: immediate return to IDLE; the in-flight instruction is discarded.

Optional Feature:
- Macro: INSTR_FETCH_PERF_EN.
- Defined:
  - cyc_count increments every RUN cycle.
  - instr_count increments on instr_valid && !stall.
  - Both clear on an accepted start and on reset, wrap at 2^CNTW, and freeze in HALTED.
- Undefined: both outputs are tied to 0; no counter flops are synthesized.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (IDLE, RUN, HALTED).
  - HALT_OP=3'b111, HALT_FUNCT=2'b11.
  - Default PCW/IW constants.
- Sub-module: fetch_perf_ctr (two clear/enable wrap counters), instantiated only under INSTR_FETCH_PERF_EN.

Test Plan:
- Reset, then start with start_addr=0x010 → next cycle pc_out=0x010, instr_valid=1; then 0x011, 0x012 on consecutive cycles.
- branch_taken=1, branch_target=0x005 while pc_out=0x012 → next cycle pc_out=0x005, then 0x006; no invalid cycle between them.
- stall held 3 cycles at pc_out=0x020 → instr and pc_out are constant, branch_taken=1 has no effect; after release pc_out=0x021.
- ROM word 9'b111_11_0000 at 0x030 → instr_valid=0 at 0x030, done=1 next cycle and held; start with start_addr=0 → done=0, pc_out=0x000.
- PCW=10, start_addr=0x3FF, no branch → pc_out sequence 0x3FF, 0x000; assert reset_n=0 mid-run → instr_valid=0 and busy=0 immediately.
- With INSTR_FETCH_PERF_EN: 4 instructions plus 2 stall cycles, then HALT → instr_count=4, cyc_count=7, both frozen afterwards.
